// File: rtl/lfsr_keystream_xor.sv
// Keystream XOR stage: snapshots a 528-bit LFSR state, XORs its low 512 bits word-by-word
// into the data stream. Optional transfer counter port word_cnt when KS_WORD_COUNT_EN is defined.
module lfsr_keystream_xor #(
  parameter int POLY_WIDTH    = 528,
  parameter int WORDS_PER_BLK = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  output logic                  busy,
  output logic                  lfsr_adv,
  input  logic [POLY_WIDTH-1:0] lfsr_state,
  input  logic [31:0]           in_data,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic [31:0]           out_data,
  output logic                  out_valid,
  output logic                  out_last,
  input  logic                  out_ready
`ifdef KS_WORD_COUNT_EN
  , output logic [31:0]         word_cnt
`endif
);

  localparam int DATA_W = 32;
  localparam int BLK_W  = DATA_W * WORDS_PER_BLK;
  localparam int IDX_W  = $clog2(WORDS_PER_BLK);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS_PER_BLK - 1);

  typedef enum logic [1:0] {IDLE, PRIME_A, PRIME_B, RUN} state_t;

  state_t            state, state_nxt;
  logic [BLK_W-1:0]  snapshot;
  logic [IDX_W-1:0]  idx;
  logic              xfer, wrap, prime_snap, adv_nxt;
  logic [DATA_W-1:0] ks_word;

  // State bits above the keystream block are discarded.
  logic unused_hi;
  assign unused_hi = ^lfsr_state[POLY_WIDTH-1:BLK_W];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && !stop) state_nxt = PRIME_A;
      PRIME_A: state_nxt = stop ? IDLE : PRIME_B;
      PRIME_B: state_nxt = stop ? IDLE : RUN;
      RUN:     if (stop) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy       = (state != IDLE);
  assign in_ready   = (state == RUN) && (!out_valid || out_ready);
  assign xfer       = in_valid && in_ready;
  assign wrap       = xfer && (idx == IDX_LAST);
  assign prime_snap = (state == PRIME_B) && !stop;
  // The LFSR lags our request by one cycle, so lfsr_state is always the block after the snapshot.
  assign adv_nxt    = ((state == IDLE) && start && !stop) || prime_snap || wrap;
  assign ks_word    = snapshot[DATA_W*int'(idx) +: DATA_W];

  // Stage p0 -> p1: snapshot/index bookkeeping and the registered output word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      lfsr_adv  <= 1'b0;
      snapshot  <= '0;
      idx       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      state    <= state_nxt;
      lfsr_adv <= adv_nxt;
      if (prime_snap || wrap) begin
        snapshot <= lfsr_state[BLK_W-1:0];
        idx      <= '0;
      end else if (xfer) begin
        idx <= idx + 1'b1;
      end
      if (xfer) begin
        out_data  <= in_data ^ ks_word;
        out_last  <= in_last;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef KS_WORD_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) word_cnt <= '0;
    else if (xfer) word_cnt <= word_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_lfsr_keystream_xor.sv
// Directed bench for lfsr_keystream_xor with a counting LFSR stub:
// word k of lfsr_state after n advances is 32'hA5A5_0000 | (n<<8) | k.
module tb_lfsr_keystream_xor;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0, stop = 1'b0;
  logic         busy, lfsr_adv;
  logic [527:0] lfsr_state;
  logic [31:0]  in_data = '0;
  logic         in_valid = 1'b0, in_last = 1'b0, in_ready;
  logic [31:0]  out_data;
  logic         out_valid, out_last;
  logic         out_ready = 1'b1;
`ifdef KS_WORD_COUNT_EN
  logic [31:0]  word_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  lfsr_keystream_xor dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .busy(busy), .lfsr_adv(lfsr_adv),
    .lfsr_state(lfsr_state), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
`ifdef KS_WORD_COUNT_EN
    .word_cnt(word_cnt),
`endif
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  logic [7:0] adv_n;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) adv_n <= '0;
    else if (lfsr_adv) adv_n <= adv_n + 8'd1;
  end

  always_comb begin
    lfsr_state = '0;
    lfsr_state[527:512] = 16'hBEEF;
    for (int k = 0; k < 16; k++) lfsr_state[32*k +: 32] = {16'hA5A5, adv_n, 8'(k)};
  end

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; stop = 1'b0; in_valid = 1'b0; in_data = '0;
    in_last = 1'b0; out_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (lfsr_adv !== 1'b0) begin n_bad++; $display("FAIL reset_adv got %b want 0", lfsr_adv); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_ovalid got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 32'h0) begin n_bad++; $display("FAIL reset_odata got %h want 0", out_data); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_iready got %b want 0", in_ready); end
`ifdef KS_WORD_COUNT_EN
    n_cmp++; if (word_cnt !== 32'h0) begin n_bad++; $display("FAIL reset_wcnt got %0d want 0", word_cnt); end
`endif
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_first_block();
    start = 1'b1; in_valid = 1'b1; in_data = '0; out_ready = 1'b1;
    @(negedge clk); start = 1'b0;
    n_cmp++; if (lfsr_adv !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0) begin
      n_bad++; $display("FAIL prime_a adv/busy/rdy got %b%b%b want 110", lfsr_adv, busy, in_ready); end
    @(negedge clk);
    n_cmp++; if (lfsr_adv !== 1'b0 || in_ready !== 1'b0) begin
      n_bad++; $display("FAIL prime_b adv/rdy got %b%b want 00", lfsr_adv, in_ready); end
    @(negedge clk);
    n_cmp++; if (lfsr_adv !== 1'b1 || in_ready !== 1'b1) begin
      n_bad++; $display("FAIL run1 adv/rdy got %b%b want 11", lfsr_adv, in_ready); end
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b1 || out_data !== (32'hA5A50100 | 32'(k))) begin
        n_bad++; $display("FAIL blk1_w%0d got %b/%h want 1/%h", k, out_valid, out_data, 32'hA5A50100 | 32'(k)); end
      n_cmp++; if (lfsr_adv !== (k == 15)) begin
        n_bad++; $display("FAIL blk1_adv%0d got %b want %b", k, lfsr_adv, k == 15); end
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b1 || out_data !== (32'hA5A50200 | 32'(k))) begin
        n_bad++; $display("FAIL blk2_w%0d got %b/%h want 1/%h", k, out_valid, out_data, 32'hA5A50200 | 32'(k)); end
      n_cmp++; if (lfsr_adv !== (k == 15)) begin
        n_bad++; $display("FAIL blk2_adv%0d got %b want %b", k, lfsr_adv, k == 15); end
      n_cmp++; if (out_last !== (k == 15)) begin
        n_bad++; $display("FAIL blk2_last%0d got %b want %b", k, out_last, k == 15); end
      in_last = (k == 14);
    end
  endtask

  task automatic test_stop_restart();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b1 || out_data !== (32'hA5A50300 | 32'(k))) begin
        n_bad++; $display("FAIL blk3_w%0d got %b/%h want 1/%h", k, out_valid, out_data, 32'hA5A50300 | 32'(k)); end
      if (k == 6) stop = 1'b1;
    end
    stop = 1'b0;
    n_cmp++; if (busy !== 1'b0 || lfsr_adv !== 1'b0 || in_ready !== 1'b0) begin
      n_bad++; $display("FAIL stop_idle busy/adv/rdy got %b%b%b want 000", busy, lfsr_adv, in_ready); end
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL stop_drain got %b want 0", out_valid); end
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL restart_rdy got %b want 1", in_ready); end
    @(negedge clk); in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'hA5A50500) begin
      n_bad++; $display("FAIL restart_w0 got %b/%h want 1/a5a50500", out_valid, out_data); end
  endtask

  task automatic test_backpressure();
    do_reset();
    start = 1'b1; in_valid = 1'b1; in_data = 32'hFFFF_FFFF; out_ready = 1'b0;
    @(negedge clk); start = 1'b0;
    @(negedge clk); @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_first_rdy got %b want 1", in_ready); end
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_cmp++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'h5A5AFEFF) begin
        n_bad++; $display("FAIL bp_hold%0d rdy/vld/data got %b%b/%h want 01/5a5afeff", c, in_ready, out_valid, out_data); end
    end
    out_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b1 || out_data !== ~(32'hA5A50100 | 32'(j + 1))) begin
        n_bad++; $display("FAIL bp_rel%0d got %b/%h want 1/%h", j, out_valid, out_data, ~(32'hA5A50100 | 32'(j + 1))); end
    end
    in_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drain got %b want 0", out_valid); end
  endtask

  task automatic test_start_stop_idle();
    do_reset();
    start = 1'b1; stop = 1'b1;
    @(negedge clk); start = 1'b0; stop = 1'b0;
    n_cmp++; if (busy !== 1'b0 || lfsr_adv !== 1'b0) begin
      n_bad++; $display("FAIL ss_idle busy/adv got %b%b want 00", busy, lfsr_adv); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || lfsr_adv !== 1'b0) begin
      n_bad++; $display("FAIL ss_idle2 busy/adv got %b%b want 00", busy, lfsr_adv); end
  endtask

  task automatic test_async_reset();
    do_reset();
    start = 1'b1; in_valid = 1'b1; in_data = 32'h1234_5678; in_last = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); @(negedge clk); @(negedge clk); @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1 || out_last !== 1'b1) begin
      n_bad++; $display("FAIL ar_pre vld/last got %b%b want 11", out_valid, out_last); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b0 || lfsr_adv !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0
                 || out_data !== 32'h0 || in_ready !== 1'b0) begin
      n_bad++; $display("FAIL ar_mid busy/adv/vld/last/rdy/data got %b%b%b%b%b/%h want 00000/0",
                        busy, lfsr_adv, out_valid, out_last, in_ready, out_data); end
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
  endtask

`ifdef KS_WORD_COUNT_EN
  task automatic test_word_count();
    do_reset();
    for (int s = 0; s < 2; s++) begin
      start = 1'b1;
      @(negedge clk); start = 1'b0;
      @(negedge clk); @(negedge clk);
      repeat (20) begin in_valid = 1'b1; @(negedge clk); end
      in_valid = 1'b0; stop = 1'b1;
      @(negedge clk); stop = 1'b0;
    end
    @(negedge clk);
    n_cmp++; if (word_cnt !== 32'd40) begin n_bad++; $display("FAIL word_cnt got %0d want 40", word_cnt); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_first_block();
    test_back_to_back();
    test_stop_restart();
    test_backpressure();
    test_start_stop_idle();
    test_async_reset();
`ifdef KS_WORD_COUNT_EN
    test_word_count();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
